// File: rtl/lane_sync_align_if.sv
// Lane-side bundle for lane_sync_align: decoded octets and status in, aligned octets and SYNC~ out.
// master drives the decoded lane; slave is the aligner.
interface lane_sync_align_if;
   logic [31:0] data_in;
   logic [3:0]  charisk_in;
   logic [3:0]  disperr_in;
   logic [3:0]  notintable_in;
   logic [31:0] data_out;
   logic        data_ready;
   logic        sync_n;
   logic [1:0]  align_pos;
   logic [1:0]  lane_state;

   modport master (
      output data_in, charisk_in, disperr_in, notintable_in,
      input  data_out, data_ready, sync_n, align_pos, lane_state
   );

   modport slave (
      input  data_in, charisk_in, disperr_in, notintable_in,
      output data_out, data_ready, sync_n, align_pos, lane_state
   );
endinterface

// File: rtl/lane_sync_align.sv
// JESD204B per-lane CGS state machine (drives SYNC~) and /R/-based octet alignment.
// Latency: /R/ word -> DATA after 1 edge, first aligned word after 3 edges; no backpressure.
module lane_sync_align #(
   parameter int K_WORDS   = 2,
   parameter int ERR_LIMIT = 4
) (
   input  logic         clk,
   input  logic         reset_b,
   lane_sync_align_if.slave lane
);

   localparam logic [2:0] K_TGT   = 3'(K_WORDS);
   localparam logic [3:0] ERR_TGT = 4'(ERR_LIMIT);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      CGS  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  k_cnt, k_cnt_nxt;
   logic [3:0]  err_cnt, err_cnt_nxt;
   logic [1:0]  pos, pos_nxt;
   logic        sync_q;

   logic [3:0]  is_k, is_r;
   logic        all_k, errored;
   logic [1:0]  first_nk;

   logic [31:0] r0, r1;
   logic [63:0] shifted;
   logic [31:0] aligned;
   logic        data_d1, data_d2;
   logic [31:0] out_q;

   always_comb begin
      is_k = '0;
      is_r = '0;
      for (int i = 0; i < 4; i++) begin
         is_k[i] = lane.charisk_in[i] && (lane.data_in[8*i +: 8] == 8'hBC) &&
                   !lane.disperr_in[i] && !lane.notintable_in[i];
         is_r[i] = lane.charisk_in[i] && (lane.data_in[8*i +: 8] == 8'h1C);
      end
   end

   assign all_k   = &is_k;
   assign errored = |(lane.disperr_in | lane.notintable_in);

   // Lowest octet that is not /K/; only that octet decides the CGS exit.
   always_comb begin
      first_nk = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!is_k[i]) begin
            first_nk = 2'(i);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      k_cnt_nxt   = k_cnt;
      err_cnt_nxt = err_cnt;
      pos_nxt     = pos;
      case (state)
         INIT: begin
            if (all_k) begin
               if (k_cnt + 3'd1 == K_TGT) begin
                  state_nxt = CGS;
                  k_cnt_nxt = 3'd0;
               end else begin
                  k_cnt_nxt = k_cnt + 3'd1;
               end
            end else begin
               k_cnt_nxt = 3'd0;
            end
         end
         CGS: begin
            if (all_k) begin
               state_nxt = CGS;
            end else if (errored) begin
               state_nxt = INIT;
            end else if (is_r[first_nk]) begin
               pos_nxt   = first_nk;
               state_nxt = DATA;
            end else begin
               state_nxt = INIT;
            end
         end
         DATA: begin
            if (errored) begin
               if (err_cnt + 4'd1 == ERR_TGT) begin
                  state_nxt   = INIT;
                  err_cnt_nxt = 4'd0;
               end else begin
                  err_cnt_nxt = err_cnt + 4'd1;
               end
            end else begin
               err_cnt_nxt = 4'd0;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state   <= INIT;
         k_cnt   <= 3'd0;
         err_cnt <= 4'd0;
         pos     <= 2'd0;
         sync_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         k_cnt   <= k_cnt_nxt;
         err_cnt <= err_cnt_nxt;
         pos     <= pos_nxt;
         sync_q  <= (state_nxt != INIT);
      end
   end

   // r1 holds the word carrying /R/ when the first aligned word is formed.
   assign shifted = {r0, r1} >> {pos, 3'b000};
   assign aligned = shifted[31:0];

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r0      <= 32'd0;
         r1      <= 32'd0;
         data_d1 <= 1'b0;
         data_d2 <= 1'b0;
         out_q   <= 32'd0;
      end else begin
         r0      <= lane.data_in;
         r1      <= r0;
         data_d1 <= (state == DATA);
         data_d2 <= data_d1;
         out_q   <= data_d1 ? aligned : 32'd0;
      end
   end

   assign lane.data_out   = out_q;
   assign lane.data_ready = data_d2;
   assign lane.sync_n     = sync_q;
   assign lane.align_pos  = pos;
   assign lane.lane_state = state;

endmodule

// File: tb/tb_lane_sync_align.sv
// Directed bench for lane_sync_align: expected octet stream queued at stimulus, checked by a monitor.
module tb_lane_sync_align;
   logic clk;
   logic reset_b;
   int   total;
   int   bad;
   logic [7:0] bq[$];
   bit   cap;
   logic [7:0] seq;

   lane_sync_align_if lane();

   lane_sync_align #(.K_WORDS(2), .ERR_LIMIT(4)) dut (
      .clk(clk),
      .reset_b(reset_b),
      .lane(lane)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every output word with data_ready must match the next 4 expected octets.
   always @(negedge clk) begin
      logic [31:0] e;
      if (lane.data_ready === 1'b1) begin
         if (bq.size() < 4) begin
            total++;
            bad++;
            $display("FAIL underflow: got %h with %0d octets queued", lane.data_out, bq.size());
         end else begin
            e = {bq[3], bq[2], bq[1], bq[0]};
            for (int i = 0; i < 4; i++) void'(bq.pop_front());
            chk("data_out", lane.data_out, e);
         end
      end else begin
         chk("idle_zero", lane.data_out, 32'd0);
      end
   end

   task automatic send(input logic [31:0] d, input logic [3:0] k,
                       input logic [3:0] de, input logic [3:0] nt);
      lane.data_in       = d;
      lane.charisk_in    = k;
      lane.disperr_in    = de;
      lane.notintable_in = nt;
      if (cap) begin
         for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic kword();
      send(32'hBCBCBCBC, 4'hF, 4'h0, 4'h0);
   endtask

   task automatic idle();
      send(32'h0, 4'h0, 4'h0, 4'h0);
   endtask

   task automatic data_word(input logic [3:0] de);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
         w[8*i +: 8] = seq;
         seq++;
      end
      send(w, 4'h0, de, 4'h0);
   endtask

   task automatic to_cgs();
      kword();
      kword();
      chk("cgs_state", 32'(lane.lane_state), 32'd1);
      chk("cgs_sync", 32'(lane.sync_n), 32'd1);
   endtask

   task automatic lock(input int p);
      logic [31:0] w;
      logic [3:0]  k;
      for (int i = 0; i < 4; i++) begin
         if (i < p) begin
            w[8*i +: 8] = 8'hBC;
            k[i] = 1'b1;
         end else if (i == p) begin
            w[8*i +: 8] = 8'h1C;
            k[i] = 1'b1;
         end else begin
            w[8*i +: 8] = seq;
            seq++;
            k[i] = 1'b0;
         end
      end
      for (int i = p; i < 4; i++) bq.push_back(w[8*i +: 8]);
      send(w, k, 4'h0, 4'h0);
      cap = 1'b1;
      chk("lock_state", 32'(lane.lane_state), 32'd2);
      chk("align_pos", 32'(lane.align_pos), 32'(p));
      data_word(4'h0);
      chk("ready_early", 32'(lane.data_ready), 32'd0);
      data_word(4'h0);
      chk("ready_first", 32'(lane.data_ready), 32'd1);
      chk("first_byte", 32'(lane.data_out[7:0]), 32'h1C);
   endtask

   // Final errored word after three consecutive ones, then watch the shutdown edges.
   task automatic tail(input int p);
      data_word(4'h2);
      cap = 1'b0;
      chk("exit_sync", 32'(lane.sync_n), 32'd0);
      chk("exit_state", 32'(lane.lane_state), 32'd0);
      idle();
      chk("ready_hold", 32'(lane.data_ready), 32'd1);
      idle();
      chk("ready_fall", 32'(lane.data_ready), 32'd0);
      chk("leftover", 32'(bq.size()), 32'(4 - p));
      bq.delete();
   endtask

   task automatic three_err();
      for (int i = 0; i < 3; i++) begin
         data_word(4'h1);
         chk("err_stay", 32'(lane.lane_state), 32'd2);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      cap     = 1'b0;
      seq     = 8'h00;
      reset_b = 1'b0;
      lane.data_in       = '0;
      lane.charisk_in    = '0;
      lane.disperr_in    = '0;
      lane.notintable_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_out", lane.data_out, 32'd0);
      chk("rst_ready", 32'(lane.data_ready), 32'd0);
      chk("rst_sync", 32'(lane.sync_n), 32'd0);
      chk("rst_pos", 32'(lane.align_pos), 32'd0);
      chk("rst_state", 32'(lane.lane_state), 32'd0);
      reset_b = 1'b1;

      // K count must be consecutive
      kword();
      chk("sync_k1", 32'(lane.sync_n), 32'd0);
      idle();
      chk("sync_break", 32'(lane.sync_n), 32'd0);
      kword();
      chk("sync_k1b", 32'(lane.sync_n), 32'd0);
      kword();
      chk("sync_rise", 32'(lane.sync_n), 32'd1);
      chk("state_cgs", 32'(lane.lane_state), 32'd1);
      kword();
      chk("cgs_hold", 32'(lane.lane_state), 32'd1);

      // p=2 with error counter exercise and /K/ passthrough in DATA
      lock(2);
      kword();
      data_word(4'h0);
      three_err();
      data_word(4'h0);
      chk("clean_stay", 32'(lane.lane_state), 32'd2);
      three_err();
      tail(2);

      to_cgs();
      lock(0);
      data_word(4'h0);
      three_err();
      tail(0);

      to_cgs();
      lock(1);
      data_word(4'h0);
      data_word(4'h0);
      three_err();
      tail(1);

      to_cgs();
      lock(3);
      data_word(4'h0);
      three_err();
      tail(3);

      // K28.3 as first non-K octet
      to_cgs();
      send(32'h557CBCBC, 4'b0111, 4'h0, 4'h0);
      chk("k283_state", 32'(lane.lane_state), 32'd0);
      chk("k283_sync", 32'(lane.sync_n), 32'd0);
      chk("k283_pos", 32'(lane.align_pos), 32'd3);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("k283_ready", 32'(lane.data_ready), 32'd0);
      end

      // asynchronous reset while in DATA
      to_cgs();
      lock(1);
      data_word(4'h0);
      data_word(4'h0);
      chk("pre_rst_ready", 32'(lane.data_ready), 32'd1);
      #2;
      reset_b = 1'b0;
      #1;
      chk("arst_data_out", lane.data_out, 32'd0);
      chk("arst_ready", 32'(lane.data_ready), 32'd0);
      chk("arst_sync", 32'(lane.sync_n), 32'd0);
      chk("arst_pos", 32'(lane.align_pos), 32'd0);
      chk("arst_state", 32'(lane.lane_state), 32'd0);
      cap = 1'b0;
      bq.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_b = 1'b1;
      to_cgs();
      lock(2);
      data_word(4'h0);
      three_err();
      tail(2);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lane_sync_align.md
# lane_sync_align

Per-lane code-group synchronisation and octet alignment for the JESD204B receiver. It takes 8b/10b-decoded 32-bit words (4 octets per clock) and runs the CGS state machine that drives SYNC~. It locates the /R/ (K28.0) character that opens the ILAS and rotates the octet stream so that /R/ lands in byte 0. It raises `data_ready` on the first aligned word, which is the write-start edge for the downstream elastic buffer.

## Interface

Parameters:
- `K_WORDS`, default 2: consecutive all-/K/ words needed to release SYNC~ (2 words = 8 octets, at least the 4 octets JESD204B requires).
- `ERR_LIMIT`, default 4: consecutive errored words in DATA that force resynchronisation, range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  lane/device clock, all logic on its rising edge.
- `reset_b`  in  1  asynchronous active-low reset.
- `data_in`  in  32  decoded octets; octet i = `data_in[8i+7:8i]`; octet 0 is earliest received.
- `charisk_in`  in  4  bit i set = octet i is a K character.
- `disperr_in`  in  4  bit i = disparity error on octet i.
- `notintable_in`  in  4  bit i = invalid code group on octet i.
- `data_out`  out  32  aligned octets, same byte order as the input.
- `data_ready`  out  1  high while `data_out` carries aligned lane data.
- `sync_n`  out  1  SYNC~ request to the transmitter, low = request sync.
- `align_pos`  out  2  latched byte position p of /R/ in its input word.
- `lane_state`  out  2  0 = INIT, 1 = CGS, 2 = DATA.

## Operation

Octet classification:
- Octet i is /K/ when `charisk_in[i]`=1, its data is 0xBC, and neither error bit is set.
- Octet i is /R/ when `charisk_in[i]`=1 and its data is 0x1C.
- A word is "errored" if any bit of `disperr_in | notintable_in` is set.
- A word is "all-K" when all 4 octets are /K/.

State machine (2-bit state, reset to INIT):
- INIT: `sync_n`=0, `data_ready`=0.
  - A 3-bit counter counts consecutive all-K words; any other word clears it.
  - When the count reaches `K_WORDS`, go to CGS and clear the counter.
- CGS: `sync_n`=1.
  - All-K words: stay.
  - Errored word: go to INIT.
  - Otherwise, p = lowest octet index that is not /K/.
    - If octet p is /R/: latch p into `align_pos` and go to DATA.
    - Else: go to INIT.
  - Octets above p are not checked.
- DATA: `sync_n`=1.
  - A 4-bit counter counts consecutive errored words; a clean word clears it.
  - When the count reaches `ERR_LIMIT`, go to INIT and clear the counter.
  - /K/ characters in DATA are passed through, not interpreted.

Alignment datapath:
- Two registers, r0 ← `data_in` and r1 ← r0, every clock regardless of state.
- Combine {r0,r1} as 64 bits, with r1 in the low half.
- Aligned word = ({r0,r1} >> 8·p)[31:0].
- `data_out` registers the aligned word when the delayed DATA flag is set, else 0.

## Timing

- Reset values: `data_out`=0, `data_ready`=0, `sync_n`=0, `align_pos`=0, `lane_state`=0; counters, r0 and r1 = 0.
- `sync_n` rises on the edge after the `K_WORDS`-th all-K word is sampled.
- Alignment latency: /R/ in word N at position p →
  - state = DATA after edge N+1;
  - `data_out[7:0]`=0x1C and `data_ready`=1 after edge N+3;
  - the following octets are contiguous, with no gaps or duplicates.
- `data_ready` is the DATA flag delayed by 2 clocks. It falls on the same edge as `data_out` goes to 0.
- Leaving DATA:
  - `sync_n` falls on the edge after the `ERR_LIMIT`-th errored word.
  - `data_ready` falls 2 clocks later.
  - `align_pos` holds its value until the next latch.
- p=0 is legal: the output is then r1 unrotated.
- Reset asserted mid-operation clears everything asynchronously. After release, the block restarts in INIT.

## Test plan

- Reset, then 1 all-K word, then 1 non-K word, then 2 all-K words → `sync_n` stays 0 until the edge after the 2nd consecutive all-K word.
- CGS, then a word with octets {0xBC,0xBC,0x1C,0x00} with charisk 0111 (octets 0–2 are K), followed by incrementing octets → `align_pos`=2; 3 clocks after that word, `data_out`=0x0100001C-style sequence with byte 0 = 0x1C; `data_ready`=1.
- Repeat the previous case for p=0, 1 and 3 → first aligned word has byte 0 = 0x1C in all cases; the octet stream is contiguous.
- CGS, then a first non-K octet of 0x7C (K28.3) → return to INIT, `sync_n`=0 next edge, `data_ready` never rises.
- DATA with `ERR_LIMIT`=4:
  - 3 errored words, then 1 clean, then 3 errored → stay in DATA;
  - a 4th consecutive errored word → `sync_n`=0 next edge, `data_ready`=0 two clocks later.
- Assert `reset_b`=0 while in DATA → all outputs 0 immediately; a new CGS sequence after release relocks normally.
